sample_capture: RTL and testbench

- Acquisition stage directly downstream of the clock divider: the divided clock, as a level, paces ADC sampling.
- Edge-detects the divided clock in the clk_in domain and stores one ADC sample per rising edge into a circular buffer.
- Applies a level/slope trigger and freezes after a fixed post-trigger count.
- Host readout logic reads the frozen buffer by address.

---
 rtl/scope_pkg.sv | 15 +
 rtl/sample_ram.sv | 32 +++
 rtl/sample_capture.sv | 151 +++++++++++++++
 tb/tb_sample_capture.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared types and default sizing for the sample-capture acquisition stage.
package scope_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH_LOG2 = 10;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT_TRIG,
        POST,
        DONE
    } state_t;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read.
module sample_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(2**DEPTH_LOG2)-1];

    // No reset on the array so it maps onto block RAM; contents survive rst.
    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sample_capture.sv
// Triggered circular-buffer capture of ADC samples paced by the divided clock.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   IDLE      | waiting for arm, no writes
//   FILL      | writing the pre-trigger samples, trigger not evaluated
//   WAIT_TRIG | writing freely around the ring, watching for the trigger
//   POST      | counting down post-trigger samples
//   DONE      | buffer frozen, readable; arm starts a new capture
module sample_capture
    import scope_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  sample_tick,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  arm,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_rising,
    input  logic [DEPTH_LOG2-1:0] pretrig,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  armed,
    output logic                  triggered,
    output logic                  done,
    output logic [DEPTH_LOG2-1:0] trig_addr
);

    localparam logic [DEPTH_LOG2-1:0] PTR_MAX = '1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    state_t                state;
    logic                  tick_q;
    logic                  sample_en;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] pre_n;
    logic [DEPTH_LOG2-1:0] fill_cnt;
    logic [DEPTH_LOG2-1:0] post_cnt;
    logic [DATA_WIDTH-1:0] prev_sample;
    logic                  prev_valid;
    logic                  rise_hit;
    logic                  fall_hit;
    logic                  trig_hit;

    assign sample_en = sample_tick & ~tick_q;

    assign wr_en = sample_en & ~rst &
                   ((state == FILL) || (state == WAIT_TRIG) || (state == POST));

    // Threshold and slope are live inputs; they are not latched at arm.
    assign rise_hit = prev_valid && (prev_sample < trig_level) && (adc_data >= trig_level);
    assign fall_hit = prev_valid && (prev_sample > trig_level) && (adc_data <= trig_level);
    assign trig_hit = trig_rising ? rise_hit : fall_hit;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state       <= IDLE;
            tick_q      <= 1'b0;
            wr_ptr      <= '0;
            pre_n       <= '0;
            fill_cnt    <= '0;
            post_cnt    <= '0;
            trig_addr   <= '0;
            prev_sample <= '0;
            prev_valid  <= 1'b0;
            armed       <= 1'b0;
            triggered   <= 1'b0;
            done        <= 1'b0;
        end else begin
            tick_q <= sample_tick;

            if (wr_en) begin
                wr_ptr      <= wr_ptr + PTR_ONE;
                prev_sample <= adc_data;
                prev_valid  <= 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        // pretrig is DEPTH_LOG2 wide, so it never exceeds DEPTH-1.
                        pre_n      <= pretrig;
                        fill_cnt   <= pretrig;
                        wr_ptr     <= '0;
                        prev_valid <= 1'b0;
                        armed      <= 1'b1;
                        triggered  <= 1'b0;
                        done       <= 1'b0;
                        state      <= (pretrig != '0) ? FILL : WAIT_TRIG;
                    end
                end

                FILL: begin
                    if (sample_en) begin
                        fill_cnt <= fill_cnt - PTR_ONE;
                        if (fill_cnt == PTR_ONE) begin
                            state <= WAIT_TRIG;
                        end
                    end
                end

                WAIT_TRIG: begin
                    if (sample_en && trig_hit) begin
                        trig_addr <= wr_ptr;
                        post_cnt  <= PTR_MAX - pre_n;
                        armed     <= 1'b0;
                        triggered <= 1'b1;
                        if (pre_n == PTR_MAX) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= POST;
                        end
                    end
                end

                POST: begin
                    if (sample_en) begin
                        post_cnt <= post_cnt - PTR_ONE;
                        if (post_cnt == PTR_ONE) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sample_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk_in  (clk_in),
        .rst     (rst),
        .we      (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (adc_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture with a 16-deep buffer.
module tb_sample_capture;

    localparam int DW = 8;
    localparam int DL = 4;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          sample_tick;
    logic [DW-1:0] adc_data;
    logic          arm;
    logic [DW-1:0] trig_level;
    logic          trig_rising;
    logic [DL-1:0] pretrig;
    logic [DL-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          armed;
    logic          triggered;
    logic          done;
    logic [DL-1:0] trig_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    sample_capture #(
        .DATA_WIDTH (DW),
        .DEPTH_LOG2 (DL)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .sample_tick (sample_tick),
        .adc_data    (adc_data),
        .arm         (arm),
        .trig_level  (trig_level),
        .trig_rising (trig_rising),
        .pretrig     (pretrig),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .armed       (armed),
        .triggered   (triggered),
        .done        (done),
        .trig_addr   (trig_addr)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One divided-clock period: high 2 cycles, low 2 cycles.
    task automatic do_sample(input int v);
        adc_data    = DW'(v);
        sample_tick = 1'b1;
        cyc(2);
        sample_tick = 1'b0;
        cyc(2);
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        cyc(1);
        arm = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int addr, input int exp);
        rd_addr = DL'(addr);
        cyc(1);
        chk(tag, int'(rd_data), exp);
    endtask

    initial begin
        rst         = 1'b1;
        sample_tick = 1'b0;
        adc_data    = '0;
        arm         = 1'b0;
        trig_level  = '0;
        trig_rising = 1'b1;
        pretrig     = '0;
        rd_addr     = '0;

        // Reset and idle
        cyc(3);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_trig_addr", int'(trig_addr), 0);
        rst = 1'b0;
        repeat (4) do_sample(8'h55);
        chk("idle_armed", int'(armed), 0);
        chk("idle_triggered", int'(triggered), 0);
        chk("idle_done", int'(done), 0);

        // Basic rising capture
        pretrig     = 4'd4;
        trig_level  = 8'd10;
        trig_rising = 1'b1;
        arm_pulse();
        chk("rise_armed", int'(armed), 1);
        for (int k = 0; k < 10; k++) do_sample(k);
        chk("rise_not_yet", int'(triggered), 0);
        do_sample(10);
        chk("rise_triggered", int'(triggered), 1);
        chk("rise_trig_addr", int'(trig_addr), 10);
        chk("rise_armed_off", int'(armed), 0);
        for (int k = 11; k < 21; k++) do_sample(k);
        chk("rise_done_early", int'(done), 0);
        do_sample(21);
        chk("rise_done", int'(done), 1);
        read_chk("rise_oldest", 6, 6);
        read_chk("rise_trig_word", 10, 10);
        read_chk("rise_addr15", 15, 15);
        read_chk("rise_addr0", 0, 16);
        read_chk("rise_newest", 5, 21);
        repeat (2) do_sample(8'hAA);
        read_chk("done_no_write6", 6, 6);
        read_chk("done_no_write0", 0, 16);

        // Falling slope with wrap, plus arm ignored in POST
        pretrig     = 4'd6;
        trig_level  = 8'd20;
        trig_rising = 1'b0;
        arm_pulse();
        chk("fall_rearm", int'(armed), 1);
        chk("fall_done_clr", int'(done), 0);
        chk("fall_trig_clr", int'(triggered), 0);
        for (int k = 0; k < 20; k++) do_sample(40 - k);
        chk("fall_not_yet", int'(triggered), 0);
        do_sample(20);
        chk("fall_triggered", int'(triggered), 1);
        chk("fall_trig_addr", int'(trig_addr), 4);
        arm_pulse();
        chk("post_arm_ignored", int'(armed), 0);
        chk("post_arm_trig", int'(triggered), 1);
        for (int k = 21; k < 29; k++) do_sample(40 - k);
        chk("fall_done_early", int'(done), 0);
        do_sample(11);
        chk("fall_done", int'(done), 1);
        read_chk("fall_oldest", 14, 26);
        read_chk("fall_addr15", 15, 25);
        read_chk("fall_addr0", 0, 24);
        read_chk("fall_trig_word", 4, 20);
        read_chk("fall_newest", 13, 11);

        // pretrig = 0: first sample has no predecessor
        pretrig     = 4'd0;
        trig_level  = 8'd15;
        trig_rising = 1'b1;
        arm_pulse();
        do_sample(20);
        chk("p0_first_no_trig", int'(triggered), 0);
        chk("p0_armed", int'(armed), 1);
        do_sample(3);
        do_sample(17);
        chk("p0_triggered", int'(triggered), 1);
        chk("p0_trig_addr", int'(trig_addr), 2);
        for (int i = 0; i < 14; i++) do_sample(100 + i);
        chk("p0_done_early", int'(done), 0);
        do_sample(114);
        chk("p0_done", int'(done), 1);
        read_chk("p0_trig_word", 2, 17);
        read_chk("p0_addr3", 3, 100);
        read_chk("p0_addr0", 0, 113);
        read_chk("p0_newest", 1, 114);

        // pretrig = 15: done on the trigger sample
        pretrig    = 4'd15;
        trig_level = 8'd20;
        arm_pulse();
        for (int k = 0; k < 20; k++) do_sample(k);
        chk("p15_not_yet", int'(triggered), 0);
        chk("p15_done_early", int'(done), 0);
        do_sample(20);
        chk("p15_done", int'(done), 1);
        chk("p15_triggered", int'(triggered), 1);
        chk("p15_trig_addr", int'(trig_addr), 4);
        read_chk("p15_oldest", 5, 5);
        read_chk("p15_trig_word", 4, 20);
        read_chk("p15_addr3", 3, 19);

        // arm coincident with sample_en: that sample is dropped
        pretrig     = 4'd2;
        trig_level  = 8'd200;
        adc_data    = 8'd77;
        sample_tick = 1'b1;
        arm         = 1'b1;
        cyc(1);
        arm = 1'b0;
        chk("coinc_armed", int'(armed), 1);
        cyc(1);
        sample_tick = 1'b0;
        cyc(2);
        do_sample(1);
        do_sample(2);
        read_chk("coinc_mem0", 0, 1);
        read_chk("coinc_mem1", 1, 2);
        do_sample(5);
        do_sample(250);
        chk("coinc_triggered", int'(triggered), 1);
        chk("coinc_trig_addr", int'(trig_addr), 3);
        do_sample(251);
        do_sample(252);
        chk("coinc_in_post", int'(done), 0);

        // Reset during POST
        rst = 1'b1;
        cyc(1);
        chk("midrst_armed", int'(armed), 0);
        chk("midrst_triggered", int'(triggered), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_trig_addr", int'(trig_addr), 0);
        rst = 1'b0;
        read_chk("midrst_mem0", 0, 1);
        read_chk("midrst_mem3", 3, 250);
        repeat (3) do_sample(8'h33);
        read_chk("idle_no_write0", 0, 1);
        read_chk("idle_no_write6", 6, 6);
        chk("idle_after_rst", int'(armed), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
